mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port (CPU/DMA) arbiter onto a single synchronous-read memory, sequenced by an IDLE/WR/RD1/RD2/DONE FSM.
// Define MEM_ARBITER_RR_EN for round-robin tie-breaking; by default port 0 has fixed priority.
module mem_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [13:0] addr0,
  input  logic [13:0] addr1,
  input  logic [9:0]  wdata0,
  input  logic [9:0]  wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic [9:0]  rdata,
  output logic        busy,
  output logic        gnt_id,
  output logic [13:0] mem_addr,
  output logic [9:0]  mem_wdata,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [9:0]  mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR   = 3'd1,
    S_RD1  = 3'd2,
    S_RD2  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  state_e      state_q;
  logic        ack0_q;
  logic        ack1_q;
  logic [9:0]  rdata_q;
  logic        busy_q;
  logic        gnt_id_q;
  logic [13:0] addr_q;
  logic [9:0]  wdata_q;
  logic        mem_write_q;
  logic        mem_read_q;

  logic        any_req;
  logic        win_id;
  logic        sel_we;
  logic [13:0] sel_addr;
  logic [9:0]  sel_wdata;

`ifdef MEM_ARBITER_RR_EN
  logic last_gnt_q;
`endif

  assign any_req = req0 | req1;

  // NOTE: give every always_comb output a default first so no path can leave it unassigned and infer a latch.
  always_comb begin
    win_id = 1'b0;
`ifdef MEM_ARBITER_RR_EN
    if (req0 && req1) win_id = ~last_gnt_q;
    else              win_id = req1;
`else
    win_id = ~req0;
`endif
  end

  assign sel_we    = win_id ? we1    : we0;
  assign sel_addr  = win_id ? addr1  : addr0;
  assign sel_wdata = win_id ? wdata1 : wdata0;

  // NOTE: all state, including the output registers, is updated with non-blocking assignments and cleared by the async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      rdata_q     <= '0;
      busy_q      <= 1'b0;
      gnt_id_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      mem_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          ack0_q <= 1'b0;
          ack1_q <= 1'b0;
          if (any_req) begin
            busy_q   <= 1'b1;
            gnt_id_q <= win_id;
            addr_q   <= sel_addr;
            wdata_q  <= sel_wdata;
            if (sel_we) begin
              state_q     <= S_WR;
              mem_write_q <= 1'b1;
            end else begin
              state_q    <= S_RD1;
              mem_read_q <= 1'b1;
            end
          end
        end
        S_WR: begin
          mem_write_q <= 1'b0;
          ack0_q      <= ~gnt_id_q;
          ack1_q      <= gnt_id_q;
          state_q     <= S_DONE;
        end
        // The memory registers its RAM output during RD1; data is valid to capture at the end of RD2.
        S_RD1: begin
          state_q <= S_RD2;
        end
        S_RD2: begin
          rdata_q    <= mem_rdata;
          mem_read_q <= 1'b0;
          ack0_q     <= ~gnt_id_q;
          ack1_q     <= gnt_id_q;
          state_q    <= S_DONE;
        end
        S_DONE: begin
          ack0_q   <= 1'b0;
          ack1_q   <= 1'b0;
          busy_q   <= 1'b0;
          gnt_id_q <= 1'b0;
          state_q  <= S_IDLE;
        end
        default: begin
          ack0_q      <= 1'b0;
          ack1_q      <= 1'b0;
          busy_q      <= 1'b0;
          gnt_id_q    <= 1'b0;
          mem_write_q <= 1'b0;
          mem_read_q  <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

`ifdef MEM_ARBITER_RR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt_q <= 1'b0;
    end else if (state_q == S_IDLE && any_req) begin
      last_gnt_q <= win_id;
    end
  end
`endif

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign rdata     = rdata_q;
  assign busy      = busy_q;
  assign gnt_id    = gnt_id_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_write = mem_write_q;
  assign mem_read  = mem_read_q;

  a_strobe_excl: assert property (@(posedge clk) disable iff (!rst_n) !(mem_write && mem_read));
  a_ack_excl:    assert property (@(posedge clk) disable iff (!rst_n) !(ack0 && ack1));
  a_wr_one:      assert property (@(posedge clk) disable iff (!rst_n) mem_write |=> !mem_write);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: table of transactions against a synchronous-read memory model,
// plus reset-abort and sustained-contention sequences.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1, we0, we1;
  logic [13:0] addr0, addr1;
  logic [9:0]  wdata0, wdata1;
  logic        ack0, ack1;
  logic [9:0]  rdata;
  logic        busy, gnt_id;
  logic [13:0] mem_addr;
  logic [9:0]  mem_wdata;
  logic        mem_write, mem_read;
  wire  [9:0]  mem_rdata;

  logic [9:0]  mem_arr [16384];
  logic [9:0]  rd_q;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy), .gnt_id(gnt_id),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_write(mem_write), .mem_read(mem_read), .mem_rdata(mem_rdata)
  );

  // Memory with a registered read port: data appears the cycle after mem_read is first seen.
  always @(posedge clk) begin
    if (mem_write) mem_arr[mem_addr] <= mem_wdata;
    if (mem_read)  rd_q <= mem_arr[mem_addr];
  end
  assign mem_rdata = mem_read ? rd_q : 10'bz;

  typedef struct {
    logic        r0, w0;
    logic [13:0] a0;
    logic [9:0]  d0;
    logic        r1, w1;
    logic [13:0] a1;
    logic [9:0]  d1;
    logic        exp_first;
    int          exp_lat;
    int          exp_wr;
    int          exp_rd;
    logic [9:0]  exp_rd0;
    logic [9:0]  exp_rd1;
    logic [9:0]  exp_end;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string name);
    check(name, {22'(rdata), ack0, ack1, busy, gnt_id, mem_write, mem_read}, 32'h0);
    check({name, "_mem"}, {8'h0, mem_addr, mem_wdata}, 32'h0);
  endtask

  task automatic run_vec(input string name, input vec_t v);
    int         cyc;
    int         lat;
    int         wr_cnt;
    int         rd_cnt;
    logic [1:0] pending;
    logic       cur;
    logic       first;
    logic       seen;
    logic [9:0] got0, got1;
    cyc = 0; lat = -1; wr_cnt = 0; rd_cnt = 0;
    seen = 1'b0; first = 1'b0; got0 = '0; got1 = '0;
    cur = v.exp_first;
    req0 = v.r0; we0 = v.w0; addr0 = v.a0; wdata0 = v.d0;
    req1 = v.r1; we1 = v.w1; addr1 = v.a1; wdata1 = v.d1;
    pending = {v.r1, v.r0};
    while (pending != 2'b00 && cyc < 30) begin
      @(posedge clk); #1;
      cyc++;
      check({name, "_ack_excl"}, 32'(ack0 & ack1), 32'h0);
      if (mem_write) begin
        wr_cnt++;
        check({name, "_wr_gnt"}, 32'(gnt_id), 32'(cur));
        check({name, "_wr_addr"}, 32'(mem_addr), 32'(cur ? v.a1 : v.a0));
        check({name, "_wr_data"}, 32'(mem_wdata), 32'(cur ? v.d1 : v.d0));
      end
      if (mem_read) begin
        rd_cnt++;
        check({name, "_rd_gnt"}, 32'(gnt_id), 32'(cur));
        check({name, "_rd_addr"}, 32'(mem_addr), 32'(cur ? v.a1 : v.a0));
      end
      if (ack0 || ack1) begin
        if (!seen) begin
          seen  = 1'b1;
          first = ack1;
          lat   = cyc;
        end
        if (ack0) begin
          req0 = 1'b0; pending[0] = 1'b0; got0 = rdata;
        end else begin
          req1 = 1'b0; pending[1] = 1'b0; got1 = rdata;
        end
        cur = ~cur;
      end
    end
    check({name, "_timeout"}, 32'(pending), 32'h0);
    check({name, "_first"}, 32'(first), 32'(v.exp_first));
    check({name, "_latency"}, 32'(lat), 32'(v.exp_lat));
    check({name, "_wr_cycles"}, 32'(wr_cnt), 32'(v.exp_wr));
    check({name, "_rd_cycles"}, 32'(rd_cnt), 32'(v.exp_rd));
    if (v.r0 && !v.w0) check({name, "_rdata0"}, 32'(got0), 32'(v.exp_rd0));
    if (v.r1 && !v.w1) check({name, "_rdata1"}, 32'(got1), 32'(v.exp_rd1));
    @(posedge clk); #1;
    check({name, "_idle"}, {30'h0, busy, gnt_id}, 32'h0);
    check({name, "_rdata_end"}, 32'(rdata), 32'(v.exp_end));
  endtask

  task automatic pulse_reset(input string name);
    #1 rst_n = 1'b0;
    #1 check_all_zero(name);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  vec_t       rv;
  logic [0:3] exp_ports;
  int         n_ack;
  int         cyc;

  initial begin
    for (int i = 0; i < 16384; i++) mem_arr[i] = '0;
    rd_q = '0;
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;

    //           r0 w0 a0        d0       r1 w1 a1        d1       1st lat wr rd rd0      rd1      end
    vecs[0] = '{1'b1, 1'b1, 14'h2005, 10'h155, 1'b0, 1'b0, 14'h0000, 10'h000, 1'b0, 2, 1, 0, 10'h000, 10'h000, 10'h000};
    vecs[1] = '{1'b0, 1'b0, 14'h0000, 10'h000, 1'b1, 1'b0, 14'h2005, 10'h000, 1'b1, 3, 0, 2, 10'h000, 10'h155, 10'h155};
    vecs[2] = '{1'b1, 1'b1, 14'h3FFF, 10'h3FF, 1'b0, 1'b0, 14'h0000, 10'h000, 1'b0, 2, 1, 0, 10'h000, 10'h000, 10'h155};
    vecs[3] = '{1'b0, 1'b0, 14'h0000, 10'h000, 1'b1, 1'b1, 14'h0000, 10'h2AA, 1'b1, 2, 1, 0, 10'h000, 10'h000, 10'h155};
    vecs[4] = '{1'b1, 1'b0, 14'h3FFF, 10'h000, 1'b1, 1'b0, 14'h0000, 10'h000, 1'b0, 3, 0, 4, 10'h3FF, 10'h2AA, 10'h2AA};
    vecs[5] = '{1'b1, 1'b1, 14'h1234, 10'h0AB, 1'b1, 1'b0, 14'h3FFF, 10'h000, 1'b0, 2, 1, 2, 10'h000, 10'h3FF, 10'h3FF};
    vecs[6] = '{1'b1, 1'b0, 14'h1234, 10'h000, 1'b0, 1'b0, 14'h0000, 10'h000, 1'b0, 3, 0, 2, 10'h0AB, 10'h000, 10'h0AB};
    vecs[7] = '{1'b0, 1'b0, 14'h0000, 10'h000, 1'b1, 1'b0, 14'h2005, 10'h000, 1'b1, 3, 0, 2, 10'h000, 10'h155, 10'h155};

    #12 check_all_zero("reset_state");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_after_reset", {30'h0, busy, gnt_id}, 32'h0);

    for (int i = 0; i < 8; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Abort a read in RD2: no ack, everything clears at once, the re-issued request completes.
    req1 = 1'b1; we1 = 1'b0; addr1 = 14'h2005;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort_in_rd2", {30'h0, mem_read, busy}, 32'h3);
    #2 rst_n = 1'b0;
    #1 check_all_zero("abort_outputs");
    req1 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_all_zero("abort_held");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("abort_idle", {30'h0, busy, ack1}, 32'h0);
    rv = '{1'b0, 1'b0, 14'h0000, 10'h000, 1'b1, 1'b0, 14'h2005, 10'h000, 1'b1, 3, 0, 2, 10'h000, 10'h155, 10'h155};
    run_vec("reissue", rv);

    // Both ports hold read requests continuously from a fresh reset.
    pulse_reset("rr_reset");
`ifdef MEM_ARBITER_RR_EN
    exp_ports = 4'b1010;
`else
    exp_ports = 4'b0000;
`endif
    req0 = 1'b1; we0 = 1'b0; addr0 = 14'h2005;
    req1 = 1'b1; we1 = 1'b0; addr1 = 14'h3FFF;
    n_ack = 0; cyc = 0;
    while (n_ack < 4 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      check("sustain_ack_excl", 32'(ack0 & ack1), 32'h0);
      if (ack0 || ack1) begin
        check($sformatf("sustain_port%0d", n_ack), 32'(ack1), 32'(exp_ports[n_ack]));
        check($sformatf("sustain_cycle%0d", n_ack), 32'(cyc), 32'(4 * n_ack + 3));
        check($sformatf("sustain_rdata%0d", n_ack), 32'(rdata), exp_ports[n_ack] ? 32'h3FF : 32'h155);
        n_ack++;
      end
    end
    check("sustain_timeout", 32'(n_ack), 32'd4);
    req0 = 1'b0; req1 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("sustain_idle", {30'h0, busy, mem_read}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
